hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_if.sv | 28 ++
 rtl/hazard_ctrl.sv | 116 +++++++++++
 tb/tb_hazard_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: Decode fields, branch/memory status in, stall/flush/forward out.
// master = pipeline datapath side, slave = hazard controller side.
interface hazard_ctrl_if;
   logic [4:0] D_rs1;
   logic [4:0] D_rs2;
   logic [4:0] D_rd;
   logic       D_we_rf;
   logic [1:0] D_sel_result;
   logic       E_pcsrc;
   logic       M_dm_ready;
   logic       F_stall;
   logic       D_stall;
   logic       D_flush;
   logic       E_flush;
   logic       pipe_freeze;
   logic [1:0] E_fwd_a;
   logic [1:0] E_fwd_b;

   modport master (
      output D_rs1, D_rs2, D_rd, D_we_rf, D_sel_result, E_pcsrc, M_dm_ready,
      input  F_stall, D_stall, D_flush, E_flush, pipe_freeze, E_fwd_a, E_fwd_b
   );

   modport slave (
      input  D_rs1, D_rs2, D_rd, D_we_rf, D_sel_result, E_pcsrc, M_dm_ready,
      output F_stall, D_stall, D_flush, E_flush, pipe_freeze, E_fwd_a, E_fwd_b
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, memory-wait freeze and
// ALU operand forwarding, driven from a shadow copy of the E/M/W register fields.
// Optional event counters are built only when HAZARD_PERF_EN is defined.
module hazard_ctrl (
   input  logic          clk,
   input  logic          rst_n,
   hazard_ctrl_if.slave  hz
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0]   perf_lw_stalls,
   output logic [31:0]   perf_flushes,
   output logic [31:0]   perf_freezes
`endif
);

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic       we;
      logic       load;
   } e_stage_t;

   typedef struct packed {
      logic [4:0] rd;
      logic       we;
   } wb_stage_t;

   e_stage_t  e_q, e_d;
   wb_stage_t m_q, m_d, w_q, w_d;

   logic freeze;
   logic lw_stall;
   logic e_flush;

   assign freeze   = ~hz.M_dm_ready;
   assign lw_stall = e_q.load & e_q.we & (e_q.rd != 5'd0) &
                     ((e_q.rd == hz.D_rs1) | (e_q.rd == hz.D_rs2));

   // A taken branch overrides the load-use stall: the stalled instruction is flushed anyway.
   // Flushes are also held off while reset is asserted so the pipeline sees no spurious clears.
   assign e_flush        = (lw_stall | hz.E_pcsrc) & ~freeze & rst_n;
   assign hz.E_flush     = e_flush;
   assign hz.D_flush     = hz.E_pcsrc & ~freeze & rst_n;
   assign hz.F_stall     = (lw_stall & ~hz.E_pcsrc) | freeze;
   assign hz.D_stall     = (lw_stall & ~hz.E_pcsrc) | freeze;
   assign hz.pipe_freeze = freeze;

   // Operand forward select; Memory stage result is newer so it wins over Writeback.
   always_comb begin
      hz.E_fwd_a = 2'b00;
      hz.E_fwd_b = 2'b00;
      if (m_q.we && (m_q.rd != 5'd0) && (m_q.rd == e_q.rs1))
         hz.E_fwd_a = 2'b10;
      else if (w_q.we && (w_q.rd != 5'd0) && (w_q.rd == e_q.rs1))
         hz.E_fwd_a = 2'b01;
      if (m_q.we && (m_q.rd != 5'd0) && (m_q.rd == e_q.rs2))
         hz.E_fwd_b = 2'b10;
      else if (w_q.we && (w_q.rd != 5'd0) && (w_q.rd == e_q.rs2))
         hz.E_fwd_b = 2'b01;
   end

   // Next shadow state: advance one stage per unfrozen clock, bubble into E on flush.
   always_comb begin
      e_d = e_q;
      m_d = m_q;
      w_d = w_q;
      if (!freeze) begin
         if (e_flush)
            e_d = '0;
         else
            e_d = '{rs1: hz.D_rs1, rs2: hz.D_rs2, rd: hz.D_rd,
                    we: hz.D_we_rf, load: (hz.D_sel_result == 2'b01)};
         m_d = '{rd: e_q.rd, we: e_q.we};
         w_d = m_q;
      end
   end

   // Shadow pipeline registers; reset discards any pending hazard.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_q <= '0;
         m_q <= '0;
         w_q <= '0;
      end else begin
         e_q <= e_d;
         m_q <= m_d;
         w_q <= w_d;
      end
   end

`ifdef HAZARD_PERF_EN
   logic [31:0] lw_cnt_q, fl_cnt_q, fz_cnt_q;

   // Saturating event counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lw_cnt_q <= '0;
         fl_cnt_q <= '0;
         fz_cnt_q <= '0;
      end else begin
         if (lw_stall && !hz.E_pcsrc && !freeze && (lw_cnt_q != 32'hFFFF_FFFF))
            lw_cnt_q <= lw_cnt_q + 32'd1;
         if (hz.E_pcsrc && !freeze && (fl_cnt_q != 32'hFFFF_FFFF))
            fl_cnt_q <= fl_cnt_q + 32'd1;
         if (freeze && (fz_cnt_q != 32'hFFFF_FFFF))
            fz_cnt_q <= fz_cnt_q + 32'd1;
      end
   end

   assign perf_lw_stalls = lw_cnt_q;
   assign perf_flushes   = fl_cnt_q;
   assign perf_freezes   = fz_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: each directed vector pushes its hand-computed
// expected outputs; a monitor pops and compares on the falling edge.
module tb_hazard_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   hazard_ctrl_if hif ();

`ifdef HAZARD_PERF_EN
   logic [31:0] p_lw, p_fl, p_fz;
`endif

   hazard_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hif)
`ifdef HAZARD_PERF_EN
      ,
      .perf_lw_stalls (p_lw),
      .perf_flushes   (p_fl),
      .perf_freezes   (p_fz)
`endif
   );

   typedef struct {
      string       name;
      logic        st;
      logic        df;
      logic        ef;
      logic        fz;
      logic [1:0]  fa;
      logic [1:0]  fb;
      bit          pchk;
      int unsigned pl;
      int unsigned pf;
      int unsigned pz;
   } exp_t;

   exp_t exp_q[$];
   int checks = 0;
   int errors = 0;
   bit done = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic step(input string nm, input bit r,
                       input int rs1, input int rs2, input int rd, input bit we, input int sel,
                       input bit pc, input bit rdy,
                       input bit st, input bit df, input bit ef, input bit fz,
                       input int fa, input int fb);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n                = r;
      hif.D_rs1            = 5'(rs1);
      hif.D_rs2            = 5'(rs2);
      hif.D_rd             = 5'(rd);
      hif.D_we_rf          = we;
      hif.D_sel_result     = 2'(sel);
      hif.E_pcsrc          = pc;
      hif.M_dm_ready       = rdy;
      e.name = nm; e.st = st; e.df = df; e.ef = ef; e.fz = fz;
      e.fa = 2'(fa); e.fb = 2'(fb);
      e.pchk = 1'b0; e.pl = 0; e.pf = 0; e.pz = 0;
      exp_q.push_back(e);
   endtask

   task automatic perf(input int unsigned l, input int unsigned f, input int unsigned z);
      exp_q[exp_q.size()-1].pchk = 1'b1;
      exp_q[exp_q.size()-1].pl = l;
      exp_q[exp_q.size()-1].pf = f;
      exp_q[exp_q.size()-1].pz = z;
   endtask

   // Monitor: compare whatever the DUT presents against the oldest expectation.
   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.name, ".F_stall"},     32'(hif.F_stall),     32'(e.st));
            chk({e.name, ".D_stall"},     32'(hif.D_stall),     32'(e.st));
            chk({e.name, ".D_flush"},     32'(hif.D_flush),     32'(e.df));
            chk({e.name, ".E_flush"},     32'(hif.E_flush),     32'(e.ef));
            chk({e.name, ".pipe_freeze"}, 32'(hif.pipe_freeze), 32'(e.fz));
            chk({e.name, ".E_fwd_a"},     32'(hif.E_fwd_a),     32'(e.fa));
            chk({e.name, ".E_fwd_b"},     32'(hif.E_fwd_b),     32'(e.fb));
`ifdef HAZARD_PERF_EN
            if (e.pchk) begin
               chk({e.name, ".perf_lw_stalls"}, p_lw, e.pl);
               chk({e.name, ".perf_flushes"},   p_fl, e.pf);
               chk({e.name, ".perf_freezes"},   p_fz, e.pz);
            end
`endif
         end
      end
   end

   initial begin
      #100000;
      if (!done) begin
         $display("FAIL watchdog actual=timeout required=finish");
         $fatal(1, "watchdog");
      end
   end

   initial begin
      hif.D_rs1 = '0; hif.D_rs2 = '0; hif.D_rd = '0; hif.D_we_rf = 1'b0;
      hif.D_sel_result = 2'b00; hif.E_pcsrc = 1'b0; hif.M_dm_ready = 1'b1;

      //    name   rst rs1 rs2 rd we sel pc rdy  st df ef fz fa fb
      // reset: stalls follow ~ready, no flush even with a branch
      step("r0",  0,  0,  0,  0, 0, 0,  1, 0,   1, 0, 0, 1, 0, 0);
      step("r1",  0,  0,  0,  0, 0, 0,  0, 1,   0, 0, 0, 0, 0, 0);
      // load-use
      step("c1",  1,  2,  0,  5, 1, 1,  0, 1,   0, 0, 0, 0, 0, 0);
      step("c2",  1,  5,  1,  6, 1, 0,  0, 1,   1, 0, 1, 0, 0, 0);
      step("c3",  1,  5,  1,  6, 1, 0,  0, 1,   0, 0, 0, 0, 0, 0);
      step("c4",  1,  0,  0,  0, 0, 0,  0, 1,   0, 0, 0, 0, 1, 0);
      // back-to-back ALU, then M-over-W priority
      step("c5",  1,  1,  2,  3, 1, 0,  0, 1,   0, 0, 0, 0, 0, 0);
      step("c6",  1,  3,  3,  4, 1, 0,  0, 1,   0, 0, 0, 0, 0, 0);
      step("c7",  1,  0,  0,  0, 0, 0,  0, 1,   0, 0, 0, 0, 2, 2);
      step("c8",  1,  0,  0,  7, 1, 0,  0, 1,   0, 0, 0, 0, 0, 0);
      step("c9",  1,  0,  0,  7, 1, 0,  0, 1,   0, 0, 0, 0, 0, 0);
      step("c10", 1,  7,  7,  8, 1, 0,  0, 1,   0, 0, 0, 0, 0, 0);
      step("c11", 1,  0,  0,  0, 0, 0,  0, 1,   0, 0, 0, 0, 2, 2);
      step("c12", 1,  0,  0,  0, 0, 0,  0, 1,   0, 0, 0, 0, 0, 0);
      // taken branch flushes a load; its would-be consumer sees no stall
      step("c13", 1,  0,  0, 10, 1, 1,  1, 1,   0, 1, 1, 0, 0, 0);
      step("c14", 1, 10, 10, 11, 1, 0,  0, 1,   0, 0, 0, 0, 0, 0);
      // branch coincident with load-use: branch wins
      step("c15", 1,  0,  0, 12, 1, 1,  0, 1,   0, 0, 0, 0, 0, 0);
      step("c16", 1, 12,  0, 13, 1, 0,  1, 1,   0, 1, 1, 0, 0, 0);
      step("c17", 1,  0,  0,  0, 0, 0,  0, 1,   0, 0, 0, 0, 0, 0);
      step("c18", 1,  0,  0,  0, 0, 0,  0, 1,   0, 0, 0, 0, 0, 0);
      // memory wait during a load-use
      step("c19", 1,  0,  0,  5, 1, 1,  0, 1,   0, 0, 0, 0, 0, 0);
      step("c20", 1,  5,  1,  6, 1, 0,  0, 0,   1, 0, 0, 1, 0, 0);
      step("c21", 1,  5,  1,  6, 1, 0,  0, 0,   1, 0, 0, 1, 0, 0);
      step("c22", 1,  5,  1,  6, 1, 0,  0, 0,   1, 0, 0, 1, 0, 0);
      step("c23", 1,  5,  1,  6, 1, 0,  0, 1,   1, 0, 1, 0, 0, 0);
      step("c24", 1,  5,  1,  6, 1, 0,  0, 1,   0, 0, 0, 0, 0, 0);
      step("c25", 1,  0,  0,  0, 0, 0,  0, 1,   0, 0, 0, 0, 1, 0);
      perf(2, 2, 3);
      // x0 never stalls or forwards
      step("c26", 1,  0,  0,  0, 1, 1,  0, 1,   0, 0, 0, 0, 0, 0);
      step("c27", 1,  0,  0, 14, 1, 0,  0, 1,   0, 0, 0, 0, 0, 0);
      step("c28", 1,  0,  0, 15, 1, 0,  0, 1,   0, 0, 0, 0, 0, 0);
      step("c29", 1,  0,  0,  0, 0, 0,  0, 1,   0, 0, 0, 0, 0, 0);
      // reset mid-freeze discards the pending load-use
      step("c30", 1,  0,  0,  5, 1, 1,  0, 1,   0, 0, 0, 0, 0, 0);
      step("c31", 1,  5,  1,  6, 1, 0,  0, 0,   1, 0, 0, 1, 0, 0);
      step("c32", 0,  5,  1,  6, 1, 0,  1, 0,   1, 0, 0, 1, 0, 0);
      step("c33", 0,  5,  1,  6, 1, 0,  1, 1,   0, 0, 0, 0, 0, 0);
      perf(0, 0, 0);
      step("c34", 1,  1,  2,  3, 1, 0,  0, 1,   0, 0, 0, 0, 0, 0);
      step("c35", 1,  3,  3,  4, 1, 0,  0, 1,   0, 0, 0, 0, 0, 0);
      step("c36", 1,  0,  0,  0, 0, 0,  0, 1,   0, 0, 0, 0, 2, 2);
      step("c37", 1,  0,  0,  0, 0, 0,  0, 1,   0, 0, 0, 0, 0, 0);

      @(posedge clk);
      @(negedge clk);
      #1;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      done = 1'b1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
